sfr_int_ctrl_v1: RTL and testbench
==================================

Name: sfr_int_ctrl_v1

Overview:
Interrupt controller and SFR-bus responder that consumes the event pulses produced by the timer, PWM and DCO peripherals. It latches events into flags, masks them with per-source enables and a global enable, and priority-encodes them. It then runs a request/acknowledge/complete handshake toward the CPU. Its SFR block sits on the same memory-mapped SFR write bus and OR-ed read bus as the other peripherals.

Parameters:
DATA_WIDTH, 32, SFR data bus width.
ADDR_WIDTH, 32, system address width.
BASE_ADDR, 32'hFFFFF864, byte address of the first SFR.
NUM_SRC, 16, number of interrupt sources (1..DATA_WIDTH-1).

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous active-low reset.
sys_addr  in  ADDR_WIDTH  CPU request address.
sys_wr_en  in  1  SFR write strobe, already qualified by the SFR region decode.
sys_sw_value  in  DATA_WIDTH  write data.
sfr_rd_dout  out  DATA_WIDTH  read data; all zeros when no register of this block is addressed.
event_in  in  NUM_SRC  peripheral event lines, sys_clk domain; bit 0 is the highest priority.
irq_ack  in  1  CPU accepts the pending request; single-cycle pulse.
irq_done  in  1  CPU finished the handler (return); single-cycle pulse.
irq_req  out  1  interrupt request to the CPU.
irq_id  out  $clog2(NUM_SRC)  index of the requested or active source.

Behaviour:
- Clock and reset are fixed: one clock, sys_clk; reset sys_rst_n is asynchronous and active-low.
- Reset values: all registers 0, FSM in IDLE, irq_req=0, irq_id=0, sfr_rd_dout=0.
- Register map (word offsets from BASE_ADDR):
  - +0x0 INTCON: bit0 GIE, read/write.
  - +0x4 IFR: flags, read; write-1-to-clear.
  - +0x8 IER: per-source enables, read/write.
  - +0xC IRQSTAT: read-only; bit31 = FSM in ACTIVE, bit30 = irq_req, low bits = irq_id.
  - Unused bits read 0. Writes to IRQSTAT are ignored.
- Reads: combinational from sys_addr, zero-padded to DATA_WIDTH.
- Writes: take effect at the sys_clk edge where sys_wr_en=1 and the address matches.
- Edge detect: a registered copy of event_in is kept. IFR[i] sets at the edge where event_in[i]=1 and the previous sample was 0. Flags set regardless of IER or GIE.
- Simultaneous hardware set and software W1C on the same bit: the set wins and the flag stays 1.
- pending = IFR & IER. The winner is the lowest set index.
- FSM:
  - IDLE -> REQ when GIE=1 and pending is non-zero. irq_id latches the winner on that edge and irq_req=1 from the next cycle.
  - REQ -> ACTIVE on irq_ack. On the same edge IFR[irq_id] is cleared and irq_req drops.
  - REQ -> IDLE (request withdrawn, irq_req drops) if GIE=0, or if pending[irq_id] goes to 0 through a software clear or an IER write, before irq_ack arrives. A withdraw condition wins over an irq_ack in the same cycle.
  - irq_id does not change while in REQ. A higher-priority arrival waits for the next arbitration; there is no preemption and no nesting.
  - ACTIVE -> IDLE on irq_done. irq_done outside ACTIVE is ignored. irq_ack outside REQ is ignored.
  - From IDLE, re-arbitration happens on the following edge. The minimum gap between requests is 1 cycle.
- Latency: event_in rises before edge N, IFR sets at N, FSM enters REQ at N+1, so irq_req is visible in the cycle after edge N+1.
- Reset asserted mid-handshake returns the block to IDLE with all flags cleared and irq_req=0 immediately, without waiting for a clock edge.

Decomposition:
- Shared package int_ctrl_pkg holds:
  - FSM enum (IDLE, REQ, ACTIVE);
  - register offsets (INTCON_OFS=0x0, IFR_OFS=0x4, IER_OFS=0x8, IRQSTAT_OFS=0xC);
  - IRQSTAT bit positions.
- Sub-module int_prio_enc: a parameterised combinational lowest-index-first encoder with outputs any and idx.
- The SFR decode, flag logic and FSM stay in the top module.

Test Plan:
1. Reset, then read all four registers -> every read returns 0. A read at BASE_ADDR+0x10 -> 0.
2. IER=0x0001, GIE=1, then pulse event_in[0] for 1 cycle -> IFR reads 0x0001 the next cycle and irq_req=1 with irq_id=0 one cycle later. Send irq_ack -> IFR=0 and irq_req=0. IRQSTAT bit31=1 until irq_done; after irq_done IRQSTAT=0.
3. IER=0x0006, pulse event_in[1] and event_in[2] in the same cycle -> irq_id=1 first. After ack+done, irq_id=2 is served. IFR goes 0x6 -> 0x4 -> 0x0.
4. GIE=0, pulse event_in[3] with IER[3]=1 -> IFR=0x0008 and irq_req stays 0. Write GIE=1 -> irq_req=1 and irq_id=3 after 1 cycle.
5. Flag in REQ, software writes IFR=0x0001 (W1C) in the same cycle as irq_ack -> request withdrawn, FSM in IDLE, irq_req=0, no ACTIVE state. Separately, a W1C in the same cycle as a rising event_in[0] -> IFR[0] stays 1.
6. Hold event_in[5] high for 10 cycles -> IFR[5] sets once. Assert sys_rst_n=0 while in ACTIVE -> irq_req=0, IRQSTAT=0 and IFR=0 without waiting for a clock edge.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared types and SFR layout for the interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_st_e;

  localparam int unsigned INTCON_OFS  = 32'h0;
  localparam int unsigned IFR_OFS     = 32'h4;
  localparam int unsigned IER_OFS     = 32'h8;
  localparam int unsigned IRQSTAT_OFS = 32'hC;

  localparam int IRQSTAT_ACT_BIT = 31;
  localparam int IRQSTAT_REQ_BIT = 30;
  localparam int INTCON_GIE_BIT  = 0;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 wins.
module int_prio_enc #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/sfr_int_ctrl_v1.sv
// Interrupt controller: event edge flags, enable masking, priority pick and
// REQ/ACK/DONE handshake to the CPU, with an SFR block on the shared bus.
module sfr_int_ctrl_v1
  import int_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFFF864,
  parameter int                    NUM_SRC    = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [ADDR_WIDTH-1:0]        sys_addr,
  input  logic                         sys_wr_en,
  input  logic [DATA_WIDTH-1:0]        sys_sw_value,
  output logic [DATA_WIDTH-1:0]        sfr_rd_dout,
  input  logic [NUM_SRC-1:0]           event_in,
  input  logic                         irq_ack,
  input  logic                         irq_done,
  output logic                         irq_req,
  output logic [$clog2(NUM_SRC)-1:0]   irq_id
);

  localparam int ID_W = $clog2(NUM_SRC);

  localparam logic [ADDR_WIDTH-1:0] A_INTCON  = ADDR_WIDTH'(BASE_ADDR + INTCON_OFS);
  localparam logic [ADDR_WIDTH-1:0] A_IFR     = ADDR_WIDTH'(BASE_ADDR + IFR_OFS);
  localparam logic [ADDR_WIDTH-1:0] A_IER     = ADDR_WIDTH'(BASE_ADDR + IER_OFS);
  localparam logic [ADDR_WIDTH-1:0] A_IRQSTAT = ADDR_WIDTH'(BASE_ADDR + IRQSTAT_OFS);

  irq_st_e            st;
  logic               gie;
  logic [NUM_SRC-1:0] ifr, ier, ev_q;

  logic               wr_intcon, wr_ifr, wr_ier;
  logic [NUM_SRC-1:0] sw_bits, rise, clr_sw, ifr_keep, ack_mask, ifr_nxt;
  logic [NUM_SRC-1:0] ier_nxt, pend_nxt, pending;
  logic               gie_nxt, withdraw, take_ack;
  logic               any;
  logic [ID_W-1:0]    win_idx;
  logic               unused_hi;

  assign sw_bits   = sys_sw_value[NUM_SRC-1:0];
  assign unused_hi = ^sys_sw_value[DATA_WIDTH-1:NUM_SRC];

  assign wr_intcon = sys_wr_en && (sys_addr == A_INTCON);
  assign wr_ifr    = sys_wr_en && (sys_addr == A_IFR);
  assign wr_ier    = sys_wr_en && (sys_addr == A_IER);

  assign rise     = event_in & ~ev_q;
  assign clr_sw   = wr_ifr ? sw_bits : '0;
  assign ifr_keep = (ifr & ~clr_sw) | rise;

  // Withdraw looks at the register values this edge will produce, so a
  // same-cycle software clear or disable beats a concurrent irq_ack.
  assign gie_nxt  = wr_intcon ? sys_sw_value[INTCON_GIE_BIT] : gie;
  assign ier_nxt  = wr_ier ? sw_bits : ier;
  assign pend_nxt = ifr_keep & ier_nxt;
  assign withdraw = !gie_nxt || !pend_nxt[irq_id];
  assign take_ack = (st == REQ) && irq_ack && !withdraw;

  // A fresh rising event on the acknowledged bit still wins over the ack clear.
  assign ack_mask = take_ack ? (NUM_SRC'(1) << irq_id) : '0;
  assign ifr_nxt  = (ifr_keep & ~ack_mask) | rise;

  assign pending = ifr & ier;

  int_prio_enc #(.N(NUM_SRC), .W(ID_W)) u_enc (
    .req (pending),
    .any (any),
    .idx (win_idx)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ev_q <= '0;
      ifr  <= '0;
      ier  <= '0;
      gie  <= 1'b0;
    end else begin
      ev_q <= event_in;
      ifr  <= ifr_nxt;
      ier  <= ier_nxt;
      gie  <= gie_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st      <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (gie && any) begin
            st      <= REQ;
            irq_req <= 1'b1;
            irq_id  <= win_idx;
          end
        end
        REQ: begin
          if (withdraw) begin
            st      <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
          end else if (irq_ack) begin
            st      <= ACTIVE;
            irq_req <= 1'b0;
          end
        end
        ACTIVE: begin
          if (irq_done) begin
            st     <= IDLE;
            irq_id <= '0;
          end
        end
        default: begin
          st      <= IDLE;
          irq_req <= 1'b0;
          irq_id  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    sfr_rd_dout = '0;
    if (sys_addr == A_INTCON) begin
      sfr_rd_dout[INTCON_GIE_BIT] = gie;
    end else if (sys_addr == A_IFR) begin
      sfr_rd_dout[NUM_SRC-1:0] = ifr;
    end else if (sys_addr == A_IER) begin
      sfr_rd_dout[NUM_SRC-1:0] = ier;
    end else if (sys_addr == A_IRQSTAT) begin
      sfr_rd_dout[IRQSTAT_ACT_BIT] = (st == ACTIVE);
      sfr_rd_dout[IRQSTAT_REQ_BIT] = irq_req;
      sfr_rd_dout[ID_W-1:0]        = irq_id;
    end
  end

endmodule

// File: tb/tb_sfr_int_ctrl_v1.sv
// Scoreboard bench for sfr_int_ctrl_v1: expectations queued at stimulus, popped at sample.
module tb_sfr_int_ctrl_v1;

  localparam logic [31:0] B       = 32'hFFFFF864;
  localparam logic [31:0] INTCON  = B + 32'h0;
  localparam logic [31:0] IFR     = B + 32'h4;
  localparam logic [31:0] IER     = B + 32'h8;
  localparam logic [31:0] IRQSTAT = B + 32'hC;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] sys_addr = '0;
  logic        sys_wr_en = 1'b0;
  logic [31:0] sys_sw_value = '0;
  logic [31:0] sfr_rd_dout;
  logic [15:0] event_in = '0;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic        irq_req;
  logic [3:0]  irq_id;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  sfr_int_ctrl_v1 dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sys_addr     (sys_addr),
    .sys_wr_en    (sys_wr_en),
    .sys_sw_value (sys_sw_value),
    .sfr_rd_dout  (sfr_rd_dout),
    .event_in     (event_in),
    .irq_ack      (irq_ack),
    .irq_done     (irq_done),
    .irq_req      (irq_req),
    .irq_id       (irq_id)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    push(tag, exp);
    sys_addr = a;
    #1;
    pop_chk(sfr_rd_dout);
  endtask

  task automatic irq(input string tag, input logic req, input logic [3:0] id);
    push(tag, {27'd0, req, id});
    pop_chk({27'd0, irq_req, irq_id});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sys_addr     = a;
    sys_sw_value = d;
    sys_wr_en    = 1'b1;
    tick();
    sys_wr_en    = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  initial begin
    // 1: reset state and out-of-range address
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    irq("rst_irq", 1'b0, 4'd0);
    rd("rst_intcon", INTCON, 32'h0);
    rd("rst_ifr", IFR, 32'h0);
    rd("rst_ier", IER, 32'h0);
    rd("rst_irqstat", IRQSTAT, 32'h0);
    rd("rd_unmapped", B + 32'h10, 32'h0);

    // 2: single source handshake
    wr(IER, 32'h0001);
    wr(INTCON, 32'h1);
    rd("gie_rd", INTCON, 32'h1);
    rd("ier_rd", IER, 32'h1);
    event_in[0] = 1'b1;
    tick();
    event_in[0] = 1'b0;
    rd("t2_ifr_set", IFR, 32'h1);
    irq("t2_no_req_yet", 1'b0, 4'd0);
    tick();
    irq("t2_req", 1'b1, 4'd0);
    rd("t2_stat_req", IRQSTAT, 32'h4000_0000);
    pulse_ack();
    rd("t2_ifr_acked", IFR, 32'h0);
    irq("t2_req_drop", 1'b0, 4'd0);
    tick();
    rd("t2_stat_active", IRQSTAT, 32'h8000_0000);
    pulse_done();
    rd("t2_stat_idle", IRQSTAT, 32'h0);

    // 3: two simultaneous sources, lower index first
    wr(IER, 32'h0006);
    event_in[2:1] = 2'b11;
    tick();
    event_in[2:1] = 2'b00;
    rd("t3_ifr_6", IFR, 32'h6);
    tick();
    irq("t3_first_id1", 1'b1, 4'd1);
    rd("t3_stat_req1", IRQSTAT, 32'h4000_0001);
    pulse_ack();
    rd("t3_ifr_4", IFR, 32'h4);
    rd("t3_stat_act1", IRQSTAT, 32'h8000_0001);
    pulse_done();
    tick();
    irq("t3_second_id2", 1'b1, 4'd2);
    pulse_ack();
    rd("t3_ifr_0", IFR, 32'h0);
    pulse_done();

    // 4: flag latched with GIE off, request follows GIE
    wr(INTCON, 32'h0);
    wr(IER, 32'h0008);
    event_in[3] = 1'b1;
    tick();
    event_in[3] = 1'b0;
    rd("t4_ifr_8", IFR, 32'h8);
    tick();
    tick();
    irq("t4_gated", 1'b0, 4'd0);
    wr(INTCON, 32'h1);
    tick();
    irq("t4_req_id3", 1'b1, 4'd3);
    pulse_ack();
    pulse_done();

    // 4b: IRQSTAT is read-only
    wr(IRQSTAT, 32'hFFFF_FFFF);
    rd("t4_irqstat_ro", IRQSTAT, 32'h0);

    // 5: W1C beats a concurrent ack
    wr(IER, 32'h0001);
    event_in[0] = 1'b1;
    tick();
    event_in[0] = 1'b0;
    tick();
    irq("t5_req", 1'b1, 4'd0);
    sys_addr     = IFR;
    sys_sw_value = 32'h1;
    sys_wr_en    = 1'b1;
    irq_ack      = 1'b1;
    tick();
    sys_wr_en    = 1'b0;
    irq_ack      = 1'b0;
    irq("t5_withdrawn", 1'b0, 4'd0);
    rd("t5_stat_idle", IRQSTAT, 32'h0);
    rd("t5_ifr_clr", IFR, 32'h0);
    tick();
    rd("t5_no_active", IRQSTAT, 32'h0);

    // 5b: hardware set beats a same-cycle W1C
    wr(IER, 32'h0);
    sys_addr     = IFR;
    sys_sw_value = 32'h1;
    sys_wr_en    = 1'b1;
    event_in[0]  = 1'b1;
    tick();
    sys_wr_en    = 1'b0;
    event_in[0]  = 1'b0;
    rd("t5_set_wins", IFR, 32'h1);
    wr(IFR, 32'h1);
    rd("t5_w1c", IFR, 32'h0);

    // 6: held level sets once; async reset in ACTIVE
    wr(IER, 32'h0020);
    event_in[5] = 1'b1;
    tick();
    rd("t6_ifr_set", IFR, 32'h20);
    tick();
    irq("t6_req_id5", 1'b1, 4'd5);
    pulse_ack();
    for (int i = 0; i < 7; i++) tick();
    rd("t6_set_once", IFR, 32'h0);
    rd("t6_active", IRQSTAT, 32'h8000_0005);
    event_in[4] = 1'b1;
    tick();
    event_in = '0;
    rd("t6_ifr_10", IFR, 32'h10);
    sys_rst_n = 1'b0;
    #1;
    irq("t6_rst_irq", 1'b0, 4'd0);
    rd("t6_rst_stat", IRQSTAT, 32'h0);
    rd("t6_rst_ifr", IFR, 32'h0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    rd("t6_rst_gie", INTCON, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
